wb_slave_decoder: RTL
=====================

WB_SLAVE_DECODER -- requirements
Module: wb_slave_decoder

Interface
REQ-001 Parameters SHALL be: NUM_SLAVES, default 2, range 2..8, number of slave ports; SLAVE_AW, default 4, per-slave address width; DW, default 8, data width; TIMEOUT, default 16, range 2..255, cycles to wait for a slave ack.
REQ-002 Local SEL_W SHALL be ceil(log2(NUM_SLAVES)), minimum 1.
REQ-003 Ports SHALL be (name direction width meaning):
- wb_clk_i  in  1  bus clock
- wb_rst_n  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  master cycle
- wb_stb_i  in  1  master strobe
- wb_we_i  in  1  master write enable
- wb_adr_i  in  SEL_W+SLAVE_AW  master address; upper SEL_W bits select the slave
- wb_dat_i  in  DW  master write data
- wb_dat_o  out  DW  read data to master
- wb_ack_o  out  1  transfer complete
- wb_err_o  out  1  transfer failed (timeout or unmapped)
- wbs_cyc_o, wbs_stb_o  out  NUM_SLAVES  one-hot per-slave cycle/strobe
- wbs_we_o  out  1  shared write enable
- wbs_adr_o  out  SLAVE_AW  shared slave address
- wbs_dat_o  out  DW  shared write data
- wbs_dat_i  in  NUM_SLAVES*DW  slave read data; slave n at bits [n*DW +: DW]
- wbs_ack_i  in  NUM_SLAVES  per-slave ack
- err_count  out  8  saturating error counter
- err_irq  out  1  level interrupt, high while err_count nonzero

Function
REQ-004 The FSM SHALL have states IDLE, ACTIVE, RESP, HOLD.
REQ-005 In IDLE, with wb_cyc_i & wb_stb_i high, the block SHALL latch the slave index, wb_we_i, the lower address and wb_dat_i, then go to ACTIVE if index < NUM_SLAVES, otherwise to RESP with error set.
REQ-006 In ACTIVE, exactly one bit of wbs_cyc_o/wbs_stb_o SHALL be high (the latched index), and wbs_we_o/wbs_adr_o/wbs_dat_o SHALL carry the latched values.
REQ-007 In ACTIVE, acks from non-selected slaves SHALL be ignored.
REQ-008 When the selected slave acks in cycle k, the block SHALL capture its data, drop its strobe at k+1, and assert wb_ack_o for exactly one cycle at k+1 (RESP), with wb_dat_o valid in that same cycle.
REQ-009 A timeout counter SHALL clear on entry to ACTIVE and increment each ACTIVE cycle.
REQ-010 If the counter reaches TIMEOUT-1 with no ack, the block SHALL drop the slave strobe and go to RESP with error set; wb_err_o SHALL pulse one cycle and wb_ack_o SHALL stay low.
REQ-011 An ack arriving in the same cycle the counter reaches TIMEOUT-1 SHALL win: normal ack, no error.
REQ-012 On an error response, wb_dat_o SHALL be all ones.
REQ-013 On an error response, err_count SHALL increment and saturate at 255.
REQ-014 A write to slave index NUM_SLAVES (when NUM_SLAVES < 2^SEL_W), lower address 0, SHALL clear err_count instead of faulting, and SHALL be acked normally.
REQ-015 From RESP the FSM SHALL go to HOLD, then from HOLD to IDLE only once wb_stb_i is low.
REQ-016 If wb_cyc_i drops during ACTIVE, the FSM SHALL abort to IDLE next cycle, with no ack, no err and no count.
REQ-017 Outside ACTIVE, all wbs_cyc_o/wbs_stb_o bits SHALL be 0.
REQ-018 All outputs SHALL be registered.
REQ-019 Minimum latency SHALL be: request seen in cycle 0, slave strobe in cycle 1, ack in cycle 2 if the slave acks combinationally in cycle 1.

Reset
REQ-020 wb_rst_n low SHALL asynchronously force IDLE, all strobes/cyc 0, wb_ack_o=0, wb_err_o=0, wb_dat_o=0, err_count=0, err_irq=0, and timeout counter 0.
REQ-021 Reset asserted mid-transfer SHALL abort it with no ack.
REQ-022 Release of reset SHALL be synchronised externally; no internal synchroniser is required.

Structure
REQ-023 FSM state encodings and the error data constant SHALL live in a shared package wb_pkg; the SEL_W computation SHALL also be defined there as a function.
REQ-024 The timeout counter SHALL be a sub-module wb_timeout (load, enable, expired) so it can be reused by the MMC controller.

Verification
REQ-025 NUM_SLAVES=2: read slave 1 addr 0x3, slave acks 1 cycle after strobe with 0x5A -> wb_ack_o one cycle, wb_dat_o=0x5A, only wbs_stb_o[1] high.
REQ-026 NUM_SLAVES=3: access to index 3 -> wb_err_o one cycle in cycle 1, wb_dat_o=0xFF, err_count=1, err_irq=1, no slave strobed.
REQ-027 TIMEOUT=16, slave never acks -> strobe high exactly 16 cycles, then wb_err_o pulse and err_count increments; slave ack at cycle 15 -> normal ack, no error.
REQ-028 Slave 0 selected, slave 1 acks spuriously -> ignored; later slave 0 ack completes normally.
REQ-029 Reset asserted during ACTIVE -> all outputs zero immediately; after release, a fresh transfer succeeds.
REQ-030 300 forced timeouts -> err_count saturates at 255; clear write -> err_count=0 and err_irq=0.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared FSM state encoding, error read-data constant and select-width helper for the Wishbone decoder
package wb_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, RESP = 2'd2, HOLD = 2'd3} state_t;
  localparam logic [63:0] ERR_DATA = '1;
  function automatic int sel_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/wb_timeout.sv
// wb_timeout: reusable ack-timeout counter; load clears, enable counts, expired flags TIMEOUT-1 reached
module wb_timeout #(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic enable,
  output logic expired
);
  logic [7:0] cnt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (load) cnt <= '0;
    else if (enable) cnt <= cnt + 8'd1;
  assign expired = cnt == 8'(TIMEOUT - 1);
endmodule

// File: rtl/wb_slave_decoder.sv
// wb_slave_decoder: Wishbone master port (wb_*) fanned out to NUM_SLAVES one-hot slave ports (wbs_*) with timeout, unmapped-error and err_count/err_irq reporting
module wb_slave_decoder
  import wb_pkg::*;
#(
  parameter int NUM_SLAVES = 2,
  parameter int SLAVE_AW   = 4,
  parameter int DW         = 8,
  parameter int TIMEOUT    = 16,
  localparam int SEL_W     = sel_w(NUM_SLAVES)
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n,
  input  logic                     wb_cyc_i,
  input  logic                     wb_stb_i,
  input  logic                     wb_we_i,
  input  logic [SEL_W+SLAVE_AW-1:0] wb_adr_i,
  input  logic [DW-1:0]            wb_dat_i,
  output logic [DW-1:0]            wb_dat_o,
  output logic                     wb_ack_o,
  output logic                     wb_err_o,
  output logic [NUM_SLAVES-1:0]    wbs_cyc_o,
  output logic [NUM_SLAVES-1:0]    wbs_stb_o,
  output logic                     wbs_we_o,
  output logic [SLAVE_AW-1:0]      wbs_adr_o,
  output logic [DW-1:0]            wbs_dat_o,
  input  logic [NUM_SLAVES*DW-1:0] wbs_dat_i,
  input  logic [NUM_SLAVES-1:0]    wbs_ack_i,
  output logic [7:0]               err_count,
  output logic                     err_irq
);
  state_t state;
  logic [SEL_W-1:0] idx, req_idx;
  logic [NUM_SLAVES-1:0] oh;
  logic sel_ack, hit, clr, req, expired;
  logic [DW-1:0] sel_dat;
  logic [7:0] cnt_inc;
  assign req_idx = wb_adr_i[SEL_W+SLAVE_AW-1 -: SEL_W];
  assign req = wb_cyc_i && wb_stb_i;
  assign hit = int'(req_idx) < NUM_SLAVES;
  // the first unused index doubles as a write-only "clear error counter" register at offset 0
  assign clr = (NUM_SLAVES < (1 << SEL_W)) && int'(req_idx) == NUM_SLAVES && wb_we_i && wb_adr_i[SLAVE_AW-1:0] == '0;
  assign cnt_inc = err_count == 8'hFF ? 8'hFF : err_count + 8'd1;
  always_comb begin
    oh = '0;
    sel_ack = 1'b0;
    sel_dat = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      oh[i] = req_idx == SEL_W'(i);
      sel_ack = idx == SEL_W'(i) ? wbs_ack_i[i] : sel_ack;
      sel_dat = idx == SEL_W'(i) ? wbs_dat_i[i*DW +: DW] : sel_dat;
    end
  end
  wb_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
    .clk(wb_clk_i),
    .rst_n(wb_rst_n),
    .load(state == IDLE && req && hit),
    .enable(state == ACTIVE),
    .expired(expired)
  );
  always_ff @(posedge wb_clk_i or negedge wb_rst_n)
    if (!wb_rst_n) begin
      state <= IDLE;
      idx <= '0;
      wbs_we_o <= 1'b0;
      wbs_adr_o <= '0;
      wbs_dat_o <= '0;
      wbs_cyc_o <= '0;
      wbs_stb_o <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      err_count <= '0;
      err_irq <= 1'b0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      case (state)
        IDLE:
          if (req) begin
            idx <= req_idx;
            wbs_we_o <= wb_we_i;
            wbs_adr_o <= wb_adr_i[SLAVE_AW-1:0];
            wbs_dat_o <= wb_dat_i;
            if (hit) begin
              state <= ACTIVE;
              wbs_cyc_o <= oh;
              wbs_stb_o <= oh;
            end else if (clr) begin
              state <= RESP;
              wb_ack_o <= 1'b1;
              err_count <= '0;
              err_irq <= 1'b0;
            end else begin
              state <= RESP;
              wb_err_o <= 1'b1;
              wb_dat_o <= ERR_DATA[DW-1:0];
              err_count <= cnt_inc;
              err_irq <= 1'b1;
            end
          end
        ACTIVE:
          if (!wb_cyc_i) begin
            state <= IDLE;
            wbs_cyc_o <= '0;
            wbs_stb_o <= '0;
          end else if (sel_ack) begin
            state <= RESP;
            wb_ack_o <= 1'b1;
            wb_dat_o <= sel_dat;
            wbs_cyc_o <= '0;
            wbs_stb_o <= '0;
          end else if (expired) begin
            state <= RESP;
            wb_err_o <= 1'b1;
            wb_dat_o <= ERR_DATA[DW-1:0];
            err_count <= cnt_inc;
            err_irq <= 1'b1;
            wbs_cyc_o <= '0;
            wbs_stb_o <= '0;
          end
        RESP: state <= HOLD;
        HOLD: state <= wb_stb_i ? HOLD : IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule
